// File: rtl/dram_ctrl_if.sv
// Request/response bundle between the last-level cache lower port and dram_ctrl.
// The master modport is the cache side. The slave modport is the controller side.
interface dram_ctrl_if #(
    parameter int unsigned B         = 64,
    parameter int unsigned ADDR_BITS = 64
);
    logic                 hc_valid_in;
    logic                 hc_ready_out;
    logic [ADDR_BITS-1:0] hc_addr_in;
    logic                 hc_we_in;
    logic [B*8-1:0]       hc_value_in;
    logic                 hc_valid_out;
    logic                 hc_ready_in;
    logic [ADDR_BITS-1:0] hc_addr_out;
    logic [B*8-1:0]       hc_value_out;

    modport master (
        output hc_valid_in, hc_addr_in, hc_we_in, hc_value_in, hc_ready_in,
        input  hc_ready_out, hc_valid_out, hc_addr_out, hc_value_out
    );

    modport slave (
        input  hc_valid_in, hc_addr_in, hc_we_in, hc_value_in, hc_ready_in,
        output hc_ready_out, hc_valid_out, hc_addr_out, hc_value_out
    );
endinterface

// File: rtl/dram_ctrl.sv
// Line-granular DRAM controller model. It keeps an in-order request FIFO and a
// line-addressed backing store, and services requests using activate/access
// latency counters.
// Optional build macro DRAM_ROW_BUFFER_EN models a single open row. With the
// row model, latency depends on whether the access is a row hit, a row
// conflict or the first access after reset.
module dram_ctrl #(
    parameter int unsigned B         = 64,
    parameter int unsigned ADDR_BITS = 64,
    parameter int unsigned MEM_LINES = 1024,
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned T_RCD     = 4,
    parameter int unsigned T_CAS     = 4,
    parameter int unsigned T_RP      = 4,
    parameter int unsigned ROW_LINES = 16
) (
    input  logic      clk_in,
    input  logic      rst_in,
    dram_ctrl_if.slave hc
);
    localparam int unsigned OFF_BITS  = $clog2(B);
    localparam int unsigned IDX_BITS  = $clog2(MEM_LINES);
    localparam int unsigned LINE_BITS = ADDR_BITS - OFF_BITS;
    localparam int unsigned PTR_BITS  = $clog2(DEPTH);
    localparam int unsigned W         = B * 8;
    // Sized for the worst-case (row conflict) latency so both builds share it.
    localparam int unsigned CNT_BITS  = $clog2(T_RP + T_RCD + T_CAS + 1);

    typedef enum logic [1:0] {StIdle, StAccess, StRespond} state_t;

    state_t                r_state;
    state_t                w_state_next;

    // Request FIFO. Only the line address is kept because offset bits are ignored.
    logic [LINE_BITS-1:0]  r_fifo_line [DEPTH];
    logic                  r_fifo_we   [DEPTH];
    logic [W-1:0]          r_fifo_data [DEPTH];
    logic [PTR_BITS-1:0]   r_wr_ptr;
    logic [PTR_BITS-1:0]   r_rd_ptr;
    logic [PTR_BITS:0]     r_count;

    // Request currently being serviced.
    logic [LINE_BITS-1:0]  r_cur_line;
    logic                  r_cur_we;
    logic [W-1:0]          r_cur_data;
    logic [CNT_BITS-1:0]   r_cnt;

    logic                  r_valid_out;
    logic [ADDR_BITS-1:0]  r_addr_out;
    logic [W-1:0]          r_value_out;

    // Backing store starts at zero and is deliberately left out of reset.
    logic [W-1:0]          r_mem [MEM_LINES] = '{default: '0};

    logic                  w_full;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_done;
    logic                  w_commit;
    logic [LINE_BITS-1:0]  w_head_line;
    logic [IDX_BITS-1:0]   w_cur_idx;
    logic [CNT_BITS-1:0]   w_lat_m1;
    logic                  w_unused_ok;

    assign w_full      = (r_count == (PTR_BITS + 1)'(DEPTH));
    assign w_push      = hc.hc_valid_in && !w_full;
    // Uses the registered count, so an entry pushed this cycle is popped next cycle.
    assign w_pop       = (r_state == StIdle) && (r_count != '0);
    assign w_done      = (r_state == StAccess) && (r_cnt == '0);
    // A write caught by reset in its final access cycle must not land.
    assign w_commit    = w_done && r_cur_we && !rst_in;
    assign w_head_line = r_fifo_line[r_rd_ptr];
    assign w_cur_idx   = r_cur_line[IDX_BITS-1:0];

`ifdef DRAM_ROW_BUFFER_EN
    localparam int unsigned ROW_BITS = $clog2(ROW_LINES);

    logic                         r_row_open;
    logic [IDX_BITS-ROW_BITS-1:0] r_row;
    logic [IDX_BITS-ROW_BITS-1:0] w_head_row;

    assign w_head_row = w_head_line[IDX_BITS-1:ROW_BITS];

    // Pick the access latency from the open-row state for the head request.
    always_comb begin
        w_lat_m1 = CNT_BITS'(T_RCD + T_CAS - 1);
        if (r_row_open && (r_row == w_head_row)) begin
            w_lat_m1 = CNT_BITS'(T_CAS - 1);
        end else if (r_row_open) begin
            w_lat_m1 = CNT_BITS'(T_RP + T_RCD + T_CAS - 1);
        end
    end

    // Any popped request, read or write, opens its row. Reset closes it.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_row_open <= 1'b0;
            r_row      <= '0;
        end else if (w_pop) begin
            r_row_open <= 1'b1;
            r_row      <= w_head_row;
        end
    end

    assign w_unused_ok = ^{hc.hc_addr_in[OFF_BITS-1:0]};
`else
    assign w_lat_m1    = CNT_BITS'(T_RCD + T_CAS - 1);
    assign w_unused_ok = ^{hc.hc_addr_in[OFF_BITS-1:0], (ROW_LINES != 0)};
`endif

    // Next-state logic for the service FSM.
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle: begin
                if (w_pop) begin
                    w_state_next = StAccess;
                end
            end
            StAccess: begin
                if (w_done) begin
                    w_state_next = r_cur_we ? StIdle : StRespond;
                end
            end
            StRespond: begin
                if (hc.hc_ready_in) begin
                    w_state_next = StIdle;
                end
            end
            default: w_state_next = StIdle;
        endcase
    end

    // FSM state, FIFO pointers, latency counter and registered response.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_state     <= StIdle;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_cnt       <= '0;
            r_valid_out <= 1'b0;
            r_addr_out  <= '0;
            r_value_out <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (w_pop) begin
                r_cnt <= w_lat_m1;
            end else if ((r_state == StAccess) && (r_cnt != '0)) begin
                r_cnt <= r_cnt - 1'b1;
            end
            if (w_done && !r_cur_we) begin
                r_valid_out <= 1'b1;
                r_addr_out  <= {r_cur_line, {OFF_BITS{1'b0}}};
                r_value_out <= r_mem[w_cur_idx];
            end else if ((r_state == StRespond) && hc.hc_ready_in) begin
                r_valid_out <= 1'b0;
            end
        end
    end

    // FIFO storage and current-request latch. Pointers gate validity, so no reset is needed.
    always_ff @(posedge clk_in) begin
        if (w_push) begin
            r_fifo_line[r_wr_ptr] <= hc.hc_addr_in[ADDR_BITS-1:OFF_BITS];
            r_fifo_we[r_wr_ptr]   <= hc.hc_we_in;
            r_fifo_data[r_wr_ptr] <= hc.hc_value_in;
        end
        if (w_pop) begin
            r_cur_line <= w_head_line;
            r_cur_we   <= r_fifo_we[r_rd_ptr];
            r_cur_data <= r_fifo_data[r_rd_ptr];
        end
    end

    // Backing-store write port. Address aliases modulo MEM_LINES.
    always_ff @(posedge clk_in) begin
        if (w_commit) begin
            r_mem[w_cur_idx] <= r_cur_data;
        end
    end

    assign hc.hc_ready_out = !w_full;
    assign hc.hc_valid_out = r_valid_out;
    assign hc.hc_addr_out  = r_addr_out;
    assign hc.hc_value_out = r_value_out;
endmodule
